// File: rtl/dmem_pipe.sv
// Pipelined big-endian data memory with handshake, latency and access checks.
// Optional error logging is built in when DMEM_ERR_LOG_EN is defined.
module dmem_pipe #(
    parameter int SIZE   = 32768,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [0:ADDR_W-1] req_addr,
    input  logic [0:1]        req_dsize,
    input  logic              req_signed,
    input  logic [0:31]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [0:31]       resp_rdata,
    output logic              resp_err
`ifdef DMEM_ERR_LOG_EN
    ,
    output logic [0:ADDR_W-1] err_addr,
    output logic [0:7]        err_cnt
`endif
);

    localparam int MW = $clog2(SIZE);
    localparam logic [ADDR_W:0] SIZE_W = (ADDR_W+1)'(SIZE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              live;
    logic [2:0]        cnt;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [1:0]        l_dsize;
    logic              l_signed;
    logic [31:0]       l_wdata;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [7:0] mem [SIZE];

    logic              accept;
    logic              fire;
    logic              acc_err;
    logic [ADDR_W:0]   end_addr;
    logic [MW-1:0]     a0;
    logic [MW-1:0]     a1;
    logic [MW-1:0]     a2;
    logic [MW-1:0]     a3;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic [7:0]        b2;
    logic [7:0]        b3;
    logic [31:0]       load_data;

    assign accept   = req_valid && req_ready;
    assign fire     = (state == WAIT) && (cnt == 3'd0);
    assign end_addr = {1'b0, l_addr} + (ADDR_W+1)'(l_dsize);

    assign a0 = l_addr[MW-1:0];
    assign a1 = a0 + MW'(1);
    assign a2 = a0 + MW'(2);
    assign a3 = a0 + MW'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        acc_err = (l_dsize == 2'd2)
               || ((l_dsize == 2'd1) && l_addr[0])
               || ((l_dsize == 2'd3) && (l_addr[1:0] != 2'd0))
               || (end_addr >= SIZE_W);
    end

    // Big-endian: the lowest address supplies the most significant byte
    always_comb begin
        load_data = 32'd0;
        case (l_dsize)
            2'd3:    load_data = {b0, b1, b2, b3};
            2'd1:    load_data = {{16{l_signed & b0[7]}}, b0, b1};
            2'd0:    load_data = {{24{l_signed & b0[7]}}, b0};
            default: load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            if (accept)
                cnt <= 3'(RD_LAT - 1);
            else if ((state == WAIT) && (cnt != 3'd0))
                cnt <= cnt - 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == 3'd0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = live && (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_we     <= 1'b0;
            l_addr   <= '0;
            l_dsize  <= 2'd0;
            l_signed <= 1'b0;
            l_wdata  <= 32'd0;
        end else if (accept) begin
            l_we     <= req_we;
            l_addr   <= req_addr;
            l_dsize  <= req_dsize;
            l_signed <= req_signed;
            l_wdata  <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (fire) begin
            rdata_q <= (l_we || acc_err) ? 32'd0 : load_data;
            err_q   <= acc_err;
        end
    end

    // Reset forces the FSM out of WAIT, so a dropped store never fires
    always_ff @(posedge clk) begin
        if (fire && l_we && !acc_err) begin
            case (l_dsize)
                2'd3: begin
                    mem[a0] <= l_wdata[31:24];
                    mem[a1] <= l_wdata[23:16];
                    mem[a2] <= l_wdata[15:8];
                    mem[a3] <= l_wdata[7:0];
                end
                2'd1: begin
                    mem[a0] <= l_wdata[15:8];
                    mem[a1] <= l_wdata[7:0];
                end
                2'd0: mem[a0] <= l_wdata[7:0];
                default: ;
            endcase
        end
    end

`ifdef DMEM_ERR_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= '0;
            err_cnt  <= 8'd0;
        end else if (fire && acc_err) begin
            err_addr <= l_addr;
            if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised successor to the single-cycle data memory, for the pipelined core's MEM stage.
- Byte-addressable, big-endian: lowest address holds the MSB.
- Request/response valid-ready handshake with configurable access latency. One request outstanding at a time.
- Adds load sign/zero extension, alignment and range checking with an error response, and a correct byte-lane store.

Parameters:
- SIZE, 32768, memory depth in bytes; must be a multiple of 4.
- ADDR_W, 32, request address width.
- RD_LAT, 1, cycles from request accept to response valid; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  [0:ADDR_W-1]  byte address.
- req_dsize  in  [0:1]  bytes-1: 3 = word, 1 = halfword, 0 = byte, 2 = reserved.
- req_signed  in  1  load result sign-extended when 1, zero-extended when 0.
- req_wdata  in  [0:31]  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  [0:31]  load data, right-justified and extended; 0 for stores and errors.
- resp_err  out  1  access was misaligned, out of range, or used the reserved size.

Behaviour:
- Reset values: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, FSM = IDLE, latency counter = 0.
  - Memory array contents are not reset.
  - rst_n is asserted asynchronously and deasserted synchronously to clk; req_ready rises on the first edge after release.
- FSM states:
  - IDLE: req_ready = 1. When req_valid && req_ready, latch we/addr/dsize/signed/wdata, load counter with RD_LAT-1, go to WAIT.
  - WAIT: req_ready = 0. Counter decrements each edge. At count 0: perform the access, register resp_rdata and resp_err, set resp_valid, go to RESP.
    - With RD_LAT = 1, WAIT lasts exactly one cycle.
  - RESP: resp_valid held with stable data until resp_valid && resp_ready. On that edge, clear resp_valid and return to IDLE.
    - No new request is accepted in the same edge; the next accept is possible one cycle later.
- Latency: accept at edge N gives resp_valid high after edge N+RD_LAT.
- Access check, evaluated on the latched request; the access is an error if any of these hold:
  - dsize = 2.
  - dsize = 1 and addr[ADDR_W-1] = 1.
  - dsize = 3 and addr[ADDR_W-2:ADDR_W-1] != 0.
  - addr + dsize >= SIZE.
  - On error: no memory write, resp_rdata = 0, resp_err = 1.
- Stores, committed on the same edge resp_valid rises:
  - word: mem[a..a+3] = wdata[0:31].
  - half: mem[a] = wdata[16:23], mem[a+1] = wdata[24:31].
  - byte: mem[a] = wdata[24:31].
  - resp_rdata = 0.
- Loads:
  - Bytes are concatenated big-endian and right-justified.
  - Upper bits are filled with the MSB of the loaded value when req_signed = 1, otherwise 0.
  - The word result ignores req_signed.
- req_valid while not in IDLE is ignored; the requester must hold the request until req_ready.
- Reset asserted mid-WAIT: the in-flight store is dropped (memory unchanged) and the FSM returns to IDLE.
- Reset asserted mid-RESP: the response is discarded.

Optional Feature:
- DMEM_ERR_LOG_EN defined:
  - Adds output err_addr [0:ADDR_W-1] and output err_cnt [0:7].
  - On each error response (at the resp_valid rise), err_addr captures the offending address and err_cnt increments, saturating at 255.
  - Both reset to 0.
- DMEM_ERR_LOG_EN undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- RD_LAT = 3, store word 0xDEADBEEF @0x100, then load word @0x100 -> store resp_valid 3 cycles after accept, resp_rdata = 0; load resp_rdata = 0xDEADBEEF, resp_err = 0.
- Store byte 0x000000F5 @0x203; load byte @0x203 with signed = 1 -> 0xFFFFFFF5; with signed = 0 -> 0x000000F5; bytes 0x200-0x202 unchanged.
- Store half 0x00008001 @0x40; load half signed -> 0xFFFF8001; load byte @0x41 unsigned -> 0x00000001.
- Misaligned and out-of-range cases, each -> resp_err = 1, resp_rdata = 0, no memory change:
  - word @0x102.
  - half @0x7FFF.
  - dsize = 2.
  - word @SIZE-2.
- Backpressure: hold resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready = 0; a new req_valid is not accepted until one cycle after the resp handshake.
- Assert rst_n = 0 during WAIT of a store word 0x12345678 @0x0 -> outputs return to reset values immediately; a subsequent load @0x0 returns the prior contents.
  - With DMEM_ERR_LOG_EN defined, after three error accesses err_cnt = 3 and err_addr holds the last offending address.
